// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a bank of common-cathode 7-segment digits,
// with blanking, leading-zero suppression and per-digit decimal points.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  input  logic                  lzs,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] LAST_PRESC = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_dp;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic                wrapped;

  logic                terminal;
  logic                wrap;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   upper_zero;
  logic                suppress;
  logic [DIGITS-1:0]   next_an;
  logic [6:0]          next_seg;
  logic                next_dp;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pattern;
    case (nib)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

  // upper_zero[k] is set when nibbles k..DIGITS-1 of the shadow are all zero.
  always_comb begin : display_logic
    logic all_zero;
    terminal   = (presc == LAST_PRESC);
    wrap       = terminal && (idx == LAST_IDX);
    nibble     = shadow_value[idx*4 +: 4];
    upper_zero = '0;
    all_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero      = all_zero && (shadow_value[4*k +: 4] == 4'h0);
      upper_zero[k] = all_zero;
    end
    suppress = lzs && (idx != '0) && upper_zero[idx];
    next_an  = '0;
    next_seg = '0;
    next_dp  = 1'b0;
    if (!blank && !suppress) begin
      next_an  = DIGITS'(1) << idx;
      next_seg = hex_decode(nibble);
      next_dp  = shadow_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
    end else begin
      if (terminal) begin
        presc <= '0;
        idx   <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
      end
    end
  end

  // frame_tick is delayed one extra stage so it lines up with digit 0 lighting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrapped    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= '0;
      seg        <= '0;
      dp         <= 1'b0;
    end else begin
      wrapped    <= wrap;
      frame_tick <= wrapped;
      an         <= next_an;
      seg        <= next_seg;
      dp         <= next_dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a cycle-count
// based reference model (DIGITS=4, REFRESH_DIV=4).
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          load;
  logic          blank;
  logic          lzs;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;

  int            errors;
  int            checks;
  int            edges;
  logic [15:0]   m_val;
  logic [3:0]    m_dp;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .blank(blank), .lzs(lzs), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h, want %h", tag, edges, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [15:0] v,
                               input logic [3:0] d, input logic b, input logic z);
    load  = l;
    value = v;
    dp_in = d;
    blank = b;
    lzs   = z;
  endtask

  // The scan position depends only on edges since reset; the shadow follows loads.
  task automatic stepCycle();
    int         d;
    logic [3:0] nib;
    logic       supp;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_ft;
    d    = (edges / RD) % D;
    nib  = 4'((m_val >> (4 * d)) & 16'hF);
    supp = lzs && (d > 0) && ((m_val >> (4 * d)) == 16'h0);
    e_an = '0; e_seg = '0; e_dp = 1'b0;
    if (!blank && !supp) begin
      e_an  = 4'(1 << d);
      e_seg = SEG_TABLE[nib];
      e_dp  = m_dp[d];
    end
    e_ft = (edges > 0) && (edges % (RD * D) == 0);
    if (load) begin
      m_val = value;
      m_dp  = dp_in;
    end
    @(posedge clk);
    #1;
    edges++;
    checkOutput("an", 16'(an), 16'(e_an));
    checkOutput("seg", 16'(seg), 16'(e_seg));
    checkOutput("dp", 16'(dp), 16'(e_dp));
    checkOutput("frame_tick", 16'(frame_tick), 16'(e_ft));
  endtask

  task automatic checkDark(input string tag);
    checkOutput({tag, "_an"}, 16'(an), 16'h0);
    checkOutput({tag, "_seg"}, 16'(seg), 16'h0);
    checkOutput({tag, "_dp"}, 16'(dp), 16'h0);
    checkOutput({tag, "_ft"}, 16'(frame_tick), 16'h0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    m_val = '0;
    m_dp  = '0;
  endtask

  // Reset is asserted between edges so its asynchronous effect is visible.
  task automatic midReset();
    #2 rst_n = 1'b0;
    #1 checkDark("async_rst");
    @(posedge clk);
    #1 checkDark("held_rst");
    releaseReset();
  endtask

  initial begin
    logic z;
    errors = 0;
    checks = 0;
    edges  = 0;
    m_val  = '0;
    m_dp   = '0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 checkDark("reset");
    releaseReset();

    repeat (20) stepCycle();

    applyStimulus(1'b1, 16'hA5C3, 4'b0100, 1'b0, 1'b0);
    stepCycle();
    load = 1'b0;
    repeat (20) stepCycle();

    for (int v = 0; v < 16; v++) begin
      applyStimulus(1'b1, {12'($urandom), 4'(v)}, 4'($urandom), 1'b0, 1'b0);
      stepCycle();
      load = 1'b0;
      repeat (15) stepCycle();
    end

    applyStimulus(1'b1, 16'h0070, 4'b1111, 1'b0, 1'b1);
    stepCycle();
    load = 1'b0;
    repeat (16) stepCycle();
    applyStimulus(1'b1, 16'h0000, 4'b1111, 1'b0, 1'b1);
    stepCycle();
    load = 1'b0;
    repeat (16) stepCycle();

    applyStimulus(1'b1, 16'h1234, 4'b1010, 1'b0, 1'b0);
    repeat (6) stepCycle();
    load = 1'b0;
    blank = 1'b1;
    repeat (5) stepCycle();
    blank = 1'b0;
    repeat (12) stepCycle();

    while (edges % RD != RD - 1) stepCycle();
    applyStimulus(1'b1, 16'h9876, 4'b0011, 1'b0, 1'b0);
    stepCycle();
    load = 1'b0;
    repeat (2) stepCycle();
    midReset();
    repeat (20) stepCycle();

    z = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 32 == 0) z = 1'($urandom);
      applyStimulus($urandom_range(0, 3) == 0,
                    16'($urandom) >> (4 * $urandom_range(0, 4)),
                    4'($urandom), $urandom_range(0, 7) == 0, z);
      stepCycle();
      if (i == 150) midReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
